// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer that shares one registered-read memory between
// an instruction-fetch port and a data port, one access every three cycles.
module mem_arbiter #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state, state_nxt;
  logic        last_d, last_d_nxt;
  logic        win_d, win_d_nxt;
  logic        we_r, we_nxt;
  logic        err_r, err_nxt;
  logic        pick_d;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic        if_gnt_nxt, if_done_nxt, if_err_nxt;
  logic        d_gnt_nxt, d_done_nxt, d_err_nxt;
  logic        read_nxt, write_nxt, busy_nxt;
  logic [31:0] addr_nxt, wdata_nxt, if_rdata_nxt, d_rdata_nxt;

  function automatic logic in_range(input logic [31:0] a);
    return a < 32'(MEM_WORDS);
  endfunction

  always_comb begin
    // On a tie the port that was not granted last wins.
    pick_d       = d_req & (~if_req | ~last_d);
    sel_addr     = pick_d ? d_addr : if_addr;
    sel_we       = pick_d & d_we;
    state_nxt    = state;
    last_d_nxt   = last_d;
    win_d_nxt    = win_d;
    we_nxt       = we_r;
    err_nxt      = err_r;
    addr_nxt     = mem_addr;
    wdata_nxt    = mem_wdata;
    if_rdata_nxt = if_rdata;
    d_rdata_nxt  = d_rdata;
    if_gnt_nxt   = 1'b0;
    if_done_nxt  = 1'b0;
    if_err_nxt   = 1'b0;
    d_gnt_nxt    = 1'b0;
    d_done_nxt   = 1'b0;
    d_err_nxt    = 1'b0;
    read_nxt     = 1'b0;
    write_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_req || d_req) begin
          win_d_nxt  = pick_d;
          last_d_nxt = pick_d;
          we_nxt     = sel_we;
          err_nxt    = !in_range(sel_addr);
          addr_nxt   = sel_addr;
          wdata_nxt  = pick_d ? d_wdata : '0;
          read_nxt   = !sel_we && in_range(sel_addr);
          write_nxt  = sel_we && in_range(sel_addr);
          d_gnt_nxt  = pick_d;
          if_gnt_nxt = !pick_d;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        state_nxt = IDLE;
        // Errors load zero; writes leave the port's read data untouched.
        if (win_d) begin
          d_done_nxt = 1'b1;
          d_err_nxt  = err_r;
          if (err_r)      d_rdata_nxt = '0;
          else if (!we_r) d_rdata_nxt = mem_rdata;
        end else begin
          if_done_nxt = 1'b1;
          if_err_nxt  = err_r;
          if (err_r)      if_rdata_nxt = '0;
          else if (!we_r) if_rdata_nxt = mem_rdata;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      win_d     <= 1'b0;
      we_r      <= 1'b0;
      err_r     <= 1'b0;
      if_gnt    <= 1'b0;
      if_done   <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_d    <= last_d_nxt;
      win_d     <= win_d_nxt;
      we_r      <= we_nxt;
      err_r     <= err_nxt;
      if_gnt    <= if_gnt_nxt;
      if_done   <= if_done_nxt;
      if_err    <= if_err_nxt;
      if_rdata  <= if_rdata_nxt;
      d_gnt     <= d_gnt_nxt;
      d_done    <= d_done_nxt;
      d_err     <= d_err_nxt;
      d_rdata   <= d_rdata_nxt;
      mem_read  <= read_nxt;
      mem_write <= write_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing scenarios, then randomized traffic
// checked by a scoreboard fed from a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_done, if_err, d_gnt, d_done, d_err;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_read, mem_write, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory device: registered read, synchronous write.
  logic [31:0] tb_mem [1024];
  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_addr[9:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= tb_mem[mem_addr[9:0]];
  end

  // Reference model state and scoreboard.
  typedef struct { bit port_d; bit err; logic [31:0] rdata; } exp_t;
  logic [31:0] ref_mem [1024];
  logic [31:0] exp_d_rd;
  bit          m_last_d;
  exp_t        exp_q[$];
  bit          gnt_q[$];
  bit          sb_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  function automatic void model_push(input bit port_d, input logic [31:0] addr,
                                     input bit we, input logic [31:0] wdata);
    exp_t e;
    e.port_d = port_d;
    e.err    = (addr >= 32'd1024);
    if (e.err) begin
      e.rdata = '0;
      if (port_d) exp_d_rd = '0;
    end else if (we) begin
      ref_mem[addr[9:0]] = wdata;
      e.rdata = exp_d_rd;
    end else begin
      e.rdata = ref_mem[addr[9:0]];
      if (port_d) exp_d_rd = e.rdata;
    end
    exp_q.push_back(e);
    gnt_q.push_back(port_d);
    m_last_d = port_d;
  endfunction

  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (if_gnt && d_gnt) fail_now("gnt_overlap");
      else if (if_gnt || d_gnt) begin
        if (gnt_q.size() == 0) fail_now("gnt_unexpected");
        else chk("gnt_port", 32'(d_gnt), 32'(gnt_q.pop_front()));
      end
      chk("err_without_done", {30'b0, if_err & ~if_done, d_err & ~d_done}, 32'd0);
      if (if_done && d_done) fail_now("done_overlap");
      else if (if_done || d_done) begin
        if (exp_q.size() == 0) fail_now("done_unexpected");
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_port", 32'(d_done), 32'(e.port_d));
          chk("done_err", 32'(d_done ? d_err : if_err), 32'(e.err));
          chk("done_rdata", d_done ? d_rdata : if_rdata, e.rdata);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'd1020 + $urandom_range(0, 8);
    return 32'($urandom_range(0, 1023));
  endfunction

  task automatic run_txn(input int mode);
    logic [31:0] ia, da, dw;
    bit          dwe, use_if, use_d, first_d;
    use_if = (mode != 1);
    use_d  = (mode != 0);
    ia = rand_addr(); da = rand_addr(); dw = $urandom(); dwe = $urandom_range(0, 1);
    @(negedge clk);
    if (use_if) begin if_addr = ia; if_req = 1'b1; end
    if (use_d)  begin d_addr = da; d_we = dwe; d_wdata = dw; d_req = 1'b1; end
    first_d = use_d && (!use_if || m_last_d == 1'b0);
    if (first_d) model_push(1'b1, da, dwe, dw);
    else         model_push(1'b0, ia, 1'b0, 32'd0);
    if (use_if && use_d) begin
      if (first_d) model_push(1'b0, ia, 1'b0, 32'd0);
      else         model_push(1'b1, da, dwe, dw);
    end
    for (int i = 0; i < 20 && (if_req || d_req); i++) begin
      tick(1);
      if (if_gnt) if_req = 1'b0;
      if (d_gnt)  d_req  = 1'b0;
    end
    if (if_req || d_req) begin
      fail_now("grant_timeout");
      if_req = 1'b0; d_req = 1'b0;
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    tick($urandom_range(0, 2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev;
    int          ngr;
    for (int i = 0; i < 1024; i++) begin
      prev = $urandom();
      tb_mem[i] = prev; ref_mem[i] = prev;
    end
    tb_mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    tick(3);
    chk("reset_ctrl", {if_gnt, if_done, if_err, d_gnt, d_done, d_err, mem_read, mem_write, busy}, 32'd0);
    chk("reset_rdata", if_rdata | d_rdata, 32'd0);

    // Reset landing in WAIT abandons the access.
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) begin if_addr = 32'd7; if_req = 1'b1; end
    tick(1); if_req = 1'b0;
    tick(1);
    chk("busy_in_wait", 32'(busy), 32'd1);
    rst_n = 1'b0; #1;
    chk("async_reset_ctrl", {if_gnt, if_done, if_err, d_gnt, d_done, d_err, mem_read, mem_write, busy}, 32'd0);
    chk("async_reset_addr", mem_addr | mem_wdata | if_rdata | d_rdata, 32'd0);
    tick(1);
    chk("no_done_after_reset", 32'(if_done), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Fetch latency.
    @(negedge clk) begin if_addr = 32'd5; if_req = 1'b1; end
    tick(1);
    chk("fetch_gnt_t1", {30'b0, if_gnt, mem_read}, 32'd3);
    chk("fetch_addr_t1", mem_addr, 32'd5);
    if_req = 1'b0;
    tick(1);
    chk("fetch_no_early_done", {30'b0, if_done, busy}, 32'd1);
    tick(1);
    chk("fetch_done_t3", {30'b0, if_done, busy}, 32'd2);
    chk("fetch_rdata", if_rdata, 32'hDEADBEEF);

    // Write then read back.
    @(negedge clk) begin d_addr = 32'd10; d_we = 1'b1; d_wdata = 32'h12345678; d_req = 1'b1; end
    prev = d_rdata;
    tick(1);
    chk("write_strobes", {29'b0, d_gnt, mem_write, mem_read}, 32'd6);
    chk("write_wdata", mem_wdata, 32'h12345678);
    d_req = 1'b0;
    tick(2);
    chk("write_done", 32'(d_done), 32'd1);
    chk("write_rdata_kept", d_rdata, prev);
    ref_mem[10] = 32'h12345678;
    @(negedge clk) begin d_we = 1'b0; d_req = 1'b1; end
    tick(1); d_req = 1'b0;
    tick(2);
    chk("readback", d_rdata, 32'h12345678);

    // Tie right after reset: fetch first.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) begin if_addr = 32'd1; d_addr = 32'd2; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1; end
    tick(1);
    chk("tie_first", {30'b0, if_gnt, d_gnt}, 32'd2);
    if_req = 1'b0;
    tick(2);
    chk("tie_if_done", 32'(if_done), 32'd1);
    tick(1);
    chk("tie_d_gnt_t4", 32'(d_gnt), 32'd1);
    d_req = 1'b0;
    tick(2);
    chk("tie_d_rdata", d_rdata, ref_mem[2]);

    // Sustained contention: strict alternation, fetch first.
    @(negedge clk) begin if_req = 1'b1; d_req = 1'b1; end
    ngr = 0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (if_gnt || d_gnt) begin
        chk("contention_order", {30'b0, if_gnt, d_gnt}, (ngr % 2 == 0) ? 32'd2 : 32'd1);
        ngr++;
      end
    end
    @(negedge clk) begin if_req = 1'b0; d_req = 1'b0; end
    chk("contention_count", 32'(ngr), 32'd4);
    tick(4);

    // Out-of-range read and last valid word.
    @(negedge clk) begin d_addr = 32'd1024; d_we = 1'b0; d_req = 1'b1; end
    tick(1);
    chk("oor_strobes_t1", {30'b0, mem_read, mem_write}, 32'd0);
    d_req = 1'b0;
    tick(2);
    chk("oor_done_err", {30'b0, d_done, d_err}, 32'd3);
    chk("oor_rdata", d_rdata, 32'd0);
    @(negedge clk) begin d_addr = 32'd1023; d_req = 1'b1; end
    tick(1); d_req = 1'b0;
    tick(2);
    chk("edge_done_noerr", {30'b0, d_done, d_err}, 32'd2);
    chk("edge_rdata", d_rdata, ref_mem[1023]);

    // Requester keeps req high through done; address change in ISSUE ignored.
    @(negedge clk) begin if_addr = 32'd3; if_req = 1'b1; end
    tick(1);
    chk("viol_addr_t1", mem_addr, 32'd3);
    if_addr = 32'd4;
    tick(1);
    chk("viol_addr_t2", mem_addr, 32'd3);
    tick(1);
    chk("viol_done", if_rdata, ref_mem[3]);
    tick(1);
    chk("viol_regrant_t4", {31'b0, if_gnt}, 32'd1);
    chk("viol_addr_t4", mem_addr, 32'd4);
    if_req = 1'b0;
    tick(2);
    chk("viol_rdata2", if_rdata, ref_mem[4]);
    tick(2);

    // Randomized traffic through the scoreboard.
    m_last_d = 1'b0;
    exp_d_rd = ref_mem[1023];
    sb_en = 1'b1;
    for (int t = 0; t < 80; t++) run_txn($urandom_range(0, 2));
    tick(4);
    chk("scoreboard_drained", 32'(exp_q.size() + gnt_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the multicycle processor's single shared 32-bit main memory (registered read, synchronous write, 1024 words). It serialises instruction-fetch and data-access requests onto the memory's `read`/`write`/`pc`/`data_in`/`data_out` pins. It applies round-robin priority on conflict, rejects out-of-range addresses, and returns read data with a fixed 3-cycle request-to-done latency. It sits between the control FSM/datapath and the memory.

## Interface
- `MEM_WORDS`, default 1024: number of memory words; valid addresses are 0 to `MEM_WORDS`-1.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `if_req`, input, 1: instruction-fetch request (read only).
- `if_addr`, input, 32: fetch word address.
- `if_gnt`, output, 1: one-cycle pulse; fetch request accepted.
- `if_done`, output, 1: one-cycle pulse; fetch complete.
- `if_err`, output, 1: one-cycle pulse with `if_done`; address out of range.
- `if_rdata`, output, 32: fetch read data; holds its value between reads.
- `d_req`, input, 1: data-port request.
- `d_we`, input, 1: data port direction; 1 = write, 0 = read.
- `d_addr`, input, 32: data word address.
- `d_wdata`, input, 32: data to write.
- `d_gnt`, output, 1: one-cycle pulse; data request accepted.
- `d_done`, output, 1: one-cycle pulse; data access complete.
- `d_err`, output, 1: one-cycle pulse with `d_done`; address out of range.
- `d_rdata`, output, 32: data-port read data; holds its value between reads.
- `mem_read`, output, 1: drives memory `read`.
- `mem_write`, output, 1: drives memory `write`.
- `mem_addr`, output, 32: drives memory `pc`.
- `mem_wdata`, output, 32: drives memory `data_in`.
- `mem_rdata`, input, 32: from memory `data_out`; valid the cycle after `mem_read` is sampled.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT.
- **IDLE:** if any request is present, pick a winner and latch its addr, we and wdata (`we` = 0 for fetch). Set the `*_gnt` pulse for the winner and go to ISSUE. With no request, stay in IDLE.
- **ISSUE:**
  - `mem_read` = !we, `mem_write` = we, `mem_addr`/`mem_wdata` = latched values.
  - Memory samples these on the closing edge.
  - Next state is WAIT.
- **WAIT:** strobes are 0.
  - On the closing edge, a read registers `mem_rdata` into the winner's rdata register.
  - On the same edge, the winner's `*_done` pulse is set and the FSM goes to IDLE.
- **Arbitration:**
  - A lone requester always wins.
  - If both ports request, the port not granted last wins.
  - `last` is a 1-bit register updated on every grant.
  - `last` resets to "data", so fetch wins the first tie.
- **Range check:** a latched address >= `MEM_WORDS` is an error.
  - ISSUE keeps both strobes at 0.
  - In WAIT, `*_done` and `*_err` are set together, and the winner's rdata is loaded with 0.
  - Latency is unchanged.
- **Writes:** `*_rdata` keeps its previous value; `*_done` still pulses.
- **Requester rule:** hold `req`, addr and wdata stable until `gnt`, then deassert `req`.
  - `req` still high in the `done` cycle is taken as a new request.
  - Inputs are not sampled in ISSUE or WAIT; `req` changes there are ignored.
- **Reset (asynchronous, immediate):**
  - FSM goes to IDLE and `last` goes to data.
  - All strobes, `gnt`, `done`, `err` and `busy` go to 0; `mem_addr`, `mem_wdata` and both rdata registers go to 0.
  - An in-flight access is abandoned with no `done`. If reset lands in ISSUE, the memory may or may not see the strobe.

## Timing
- Cycle T: IDLE with `req` high.
- Cycle T+1: ISSUE; `gnt` and the memory strobes are high.
- Cycle T+2: WAIT; `mem_rdata` is valid.
- Cycle T+3: `done` and rdata are valid, and the FSM is back in IDLE.
- Throughput is one access per 3 cycles. A request present in cycle T+3 is granted in T+4.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `busy` is high in T+1 and T+2.
- `if_gnt` and `d_gnt` are never high in the same cycle, and likewise for `done`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WAIT → all outputs 0 in the same cycle, no `done`; after release, fetch of addr 5 (mem[5]=32'hDEADBEEF) → `if_gnt` at T+1, `mem_read`=1 with `mem_addr`=5 at T+1, `if_done` with `if_rdata`=32'hDEADBEEF at T+3.
- **Write then read back:** data write addr 10, wdata 32'h12345678 → `mem_write`=1 at T+1, `d_done` at T+3, `d_rdata` unchanged; then a data read of addr 10 → `d_rdata`=32'h12345678.
- **Tie after reset:** both ports request → fetch granted first; data is granted the cycle after `if_done`.
- **Sustained contention:** both ports hold `req` for 12 cycles → grants strictly alternate fetch, data, fetch, data.
- **Out of range:** data read addr 1024 → `mem_read` and `mem_write` stay 0, `d_done`=`d_err`=1 at T+3, `d_rdata`=0; addr 1023 → no error.
- **Requester-rule violation:** fetch keeps `req` high through `done` → a second grant follows at T+4; changing `if_addr` during ISSUE does not alter `mem_addr`.
